// File: rtl/mm_job_scheduler.sv
// Round-robin job scheduler for the single matrix compute engine: grants one
// requester, runs the per-tile start/done handshake and reports completion.
//
// state   | meaning
// IDLE    | no job; round-robin grant from pending requests
// START   | eng_start high, watchdog counting, waiting for eng_done
// RELEASE | eng_start low, waiting for eng_done to drop
// CPL     | one-cycle completion pulse to the owning requester
module mm_job_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int K_W     = 2,
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*K_W-1:0]    req_k,
  input  logic [NUM_REQ*TILE_W-1:0] req_tiles,
  output logic [NUM_REQ-1:0]        cpl_valid,
  output logic                      cpl_err,
  output logic                      eng_start,
  input  logic                      eng_done,
  output logic [K_W-1:0]            eng_cfg_k,
  output logic [SEL_W-1:0]          eng_sel,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, START, RELEASE, CPL} state_t;

  state_t              state;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    win;
  logic                found;
  logic [K_W-1:0]      win_k;
  logic [TILE_W-1:0]   win_tiles;
  logic [TILE_W-1:0]   tiles_left;
  logic [WD_W-1:0]     wd;

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    win       = '0;
    win_k     = '0;
    win_tiles = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        win       = SEL_W'(idx);
        win_k     = req_k[idx*K_W +: K_W];
        win_tiles = req_tiles[idx*TILE_W +: TILE_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[win] = 1'b1;
  end

  assign busy    = (state != IDLE);
  assign eng_sel = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel_q       <= '0;
      eng_cfg_k   <= '0;
      tiles_left  <= '0;
      wd          <= '0;
      eng_start   <= 1'b0;
      cpl_valid   <= '0;
      cpl_err     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cpl_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            sel_q      <= win;
            eng_cfg_k  <= win_k;
            tiles_left <= win_tiles;
            wd         <= '0;
            rr_ptr     <= (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            // Empty or zero-depth jobs never touch the engine.
            if (win_tiles == '0 || win_k == '0) begin
              state          <= CPL;
              cpl_valid[win] <= 1'b1;
              cpl_err        <= 1'b1;
            end else begin
              state     <= START;
              eng_start <= 1'b1;
            end
          end
        end
        START: begin
          if (eng_done) begin
            state     <= RELEASE;
            eng_start <= 1'b0;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err_timeout      <= 1'b1;
            eng_start        <= 1'b0;
            state            <= CPL;
            cpl_valid[sel_q] <= 1'b1;
            cpl_err          <= 1'b1;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        RELEASE: begin
          if (!eng_done) begin
            if (tiles_left == TILE_W'(1)) begin
              state            <= CPL;
              cpl_valid[sel_q] <= 1'b1;
              cpl_err          <= 1'b0;
            end else begin
              tiles_left <= tiles_left - 1'b1;
              wd         <= '0;
              eng_start  <= 1'b1;
              state      <= START;
            end
          end
        end
        CPL: begin
          state   <= IDLE;
          cpl_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Scoreboard bench for mm_job_scheduler: directed jobs push expected grants and
// completions; a negedge monitor pops and compares as the DUT presents them.
module tb_mm_job_scheduler;
  localparam int NUM_REQ = 2;
  localparam int K_W     = 2;
  localparam int TILE_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int SEL_W   = 1;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*K_W-1:0]    req_k;
  logic [NUM_REQ*TILE_W-1:0] req_tiles;
  logic [NUM_REQ-1:0]        cpl_valid;
  logic                      cpl_err;
  logic                      eng_start;
  logic                      eng_done;
  logic [K_W-1:0]            eng_cfg_k;
  logic [SEL_W-1:0]          eng_sel;
  logic                      busy;
  logic                      err_timeout;

  mm_job_scheduler #(
    .NUM_REQ(NUM_REQ), .K_W(K_W), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_k(req_k), .req_tiles(req_tiles),
    .cpl_valid(cpl_valid), .cpl_err(cpl_err),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_cfg_k(eng_cfg_k), .eng_sel(eng_sel),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int r; int k; } grant_t;
  typedef struct { int r; bit err; } cpl_t;
  grant_t gq[$];
  cpl_t   cq[$];

  int tests = 0;
  int fails = 0;
  int cur_sel = 0, cur_k = 0;
  int start_cnt = 0, cpl_cnt = 0, grant_cnt = 0;
  int high_run = 0, low_run = 0, last_high = 0, last_gap = 0;
  logic prev_start = 1'b0;
  int lat = 5;    // engine latency in cycles; 0 = never finishes
  int hold = 0;   // extra cycles done stays high after start drops

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Engine model
  initial begin
    int cnt, hcnt;
    cnt = 0;
    hcnt = 0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_done = 1'b0; cnt = 0; hcnt = 0;
      end else if (eng_start && !eng_done) begin
        cnt++;
        if (lat != 0 && cnt >= lat) begin
          eng_done = 1'b1; cnt = 0; hcnt = 0;
        end
      end else if (!eng_start && eng_done) begin
        if (hcnt >= hold) begin
          eng_done = 1'b0; hcnt = 0;
        end else hcnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      grant_t g;
      cpl_t   c;
      @(negedge clk);
      if (req_ready != '0) begin
        grant_cnt++;
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (gq.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'd0);
        else begin
          g = gq.pop_front();
          chk("grant_idx", 32'(req_ready), 32'(1 << g.r));
          cur_sel = g.r;
          cur_k   = g.k;
        end
      end
      if (cpl_valid != '0) begin
        cpl_cnt++;
        if (cq.size() == 0) chk("unexpected_cpl", 32'(cpl_valid), 32'd0);
        else begin
          c = cq.pop_front();
          chk("cpl_vec", 32'(cpl_valid), 32'(1 << c.r));
          chk("cpl_err", 32'(cpl_err), 32'(c.err));
        end
      end
      if (eng_start) begin
        chk("eng_sel", 32'(eng_sel), 32'(cur_sel));
        chk("eng_cfg_k", 32'(eng_cfg_k), 32'(cur_k));
        if (!prev_start) begin
          start_cnt++;
          last_gap = low_run;
          low_run  = 0;
        end
        high_run++;
      end else begin
        if (prev_start) begin
          last_high = high_run;
          high_run  = 0;
        end
        low_run++;
      end
      prev_start = eng_start;
    end
  end

  task automatic set_req(input int r, input int k, input int t);
    req_k[r*K_W +: K_W]          = K_W'(k);
    req_tiles[r*TILE_W +: TILE_W] = TILE_W'(t);
  endtask

  task automatic grant_only(input int r, input int k, input int t);
    bit got;
    got = 1'b0;
    gq.push_back('{r, k});
    set_req(r, k, t);
    req_valid[r] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin got = 1'b1; break; end
    end
    if (!got) expire("grant_wait");
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_cpl(input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (cpl_cnt >= target) begin got = 1'b1; break; end
    end
    if (!got) expire("cpl_wait");
    #1;
  endtask

  task automatic issue(input int r, input int k, input int t, input bit err);
    int base;
    base = cpl_cnt;
    cq.push_back('{r, err});
    grant_only(r, k, t);
    wait_cpl(base + 1);
  endtask

  initial begin
    int s0, g0, c0;
    bit got;
    rst_n = 1'b0;
    req_valid = '0;
    req_k = '0;
    req_tiles = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_eng_sel_k", 32'({eng_sel, eng_cfg_k}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters held valid: grants 0,1,0,1
    g0 = grant_cnt;
    c0 = cpl_cnt;
    set_req(0, 1, 1);
    set_req(1, 3, 1);
    for (int j = 0; j < 4; j++) begin
      gq.push_back('{j % 2, (j % 2 == 0) ? 1 : 3});
      cq.push_back('{j % 2, 1'b0});
    end
    @(posedge clk);
    #1 req_valid = 2'b11;
    wait_cpl(c0 + 4);
    req_valid = 2'b00;
    chk("alt_grant_count", 32'(grant_cnt - g0), 32'd4);

    // Three-tile job on requester 0
    s0 = start_cnt;
    issue(0, 2, 3, 1'b0);
    chk("t3_start_pulses", 32'(start_cnt - s0), 32'd3);
    chk("t3_restart_gap", 32'(last_gap), 32'd1);

    // Illegal jobs: tiles=0, then k=0
    s0 = start_cnt;
    issue(1, 1, 0, 1'b1);
    chk("tiles0_no_start", 32'(start_cnt - s0), 32'd0);
    issue(0, 0, 2, 1'b1);
    chk("k0_no_start", 32'(start_cnt - s0), 32'd0);

    // Engine holds done 3 cycles after start drops
    hold = 3;
    s0 = start_cnt;
    issue(1, 2, 2, 1'b0);
    chk("hold_start_pulses", 32'(start_cnt - s0), 32'd2);
    chk("hold_restart_gap", 32'(last_gap), 32'd4);
    hold = 0;

    // Hung engine: watchdog aborts after TIMEOUT cycles
    lat = 0;
    chk("pre_timeout_flag", 32'(err_timeout), 32'd0);
    s0 = start_cnt;
    issue(0, 3, 2, 1'b1);
    chk("timeout_high_len", 32'(last_high), 32'd16);
    chk("timeout_starts", 32'(start_cnt - s0), 32'd1);
    chk("timeout_flag", 32'(err_timeout), 32'd1);
    lat = 5;
    issue(1, 1, 1, 1'b0);
    chk("timeout_sticky", 32'(err_timeout), 32'd1);

    // Reset during tile 2 of a job on requester 0
    s0 = start_cnt;
    grant_only(0, 2, 3);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (start_cnt - s0 >= 2) begin got = 1'b1; break; end
    end
    if (!got) expire("tile2_wait");
    #3 rst_n = 1'b0;
    #1;
    chk("arst_eng_start", 32'(eng_start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err_timeout", 32'(err_timeout), 32'd0);
    chk("arst_eng_sel", 32'(eng_sel), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    c0 = cpl_cnt;
    set_req(0, 1, 1);
    set_req(1, 3, 1);
    gq.push_back('{0, 1});
    cq.push_back('{0, 1'b0});
    gq.push_back('{1, 3});
    cq.push_back('{1, 1'b0});
    req_valid = 2'b11;
    wait_cpl(c0 + 2);
    req_valid = 2'b00;

    repeat (3) @(posedge clk);
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("cpl_queue_drained", 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
